// File: rtl/parking_gate_ctrl.sv
// ============================================================================
// parking_gate_ctrl
// ----------------------------------------------------------------------------
// Transaction sequencer between the keypad/sensor front end and the floor/ID
// bookkeeping block. For every presented ID it:
//   * drives MODE so the bookkeeping block evaluates the ID,
//   * decides (entry / alternative-floor offer / exit / deny / admin toggle),
//   * issues a one-cycle action_taken commit code,
//   * opens the physical gate or lights the deny lamp.
// An admin ID toggles a restrict lock. While the lock is active every
// non-admin request is denied and MODE idles at 2.
//
// Ports
//   CLK                   system clock, rising edge
//   RST_N                 asynchronous active-low reset
//   ID_READY              one-cycle pulse, ID and EXIT_REQ valid (IDLE only)
//   EXIT_REQ              0 = entry request, 1 = exit request
//   id_valid              bookkeeping: ID known and in correct state for MODE
//   id_special            bookkeeping: special user valid for MODE
//   adminId_valid         bookkeeping: ID is an admin
//   chosen_flr_full       bookkeeping: chosen floor is full
//   alternative_flr_full  bookkeeping: alternative floor is full
//   USER_ACCEPT           user accepts alternative floor (level)
//   USER_DECLINE          user declines alternative floor (level)
//   CAR_PASSED            gate sensor pulse
//   MODE[1:0]             0 = enter, 1 = exit, 2 = restrict
//   action_taken[1:0]     0 none, 1 alt floor, 2 chosen floor, 3 exit commit
//   GATE_OPEN             gate actuator
//   DENY                  deny lamp
//   ALT_OFFER             alternative-floor prompt lamp
//   BUSY                  high whenever not idle
//   RESTRICTED            restrict lock active
// All outputs are registered.
// ============================================================================
module parking_gate_ctrl #(
   parameter int ALT_TIMEOUT  = 200,
   parameter int GATE_TIMEOUT = 500,
   parameter int DENY_CYCLES  = 50,
   parameter int CW           = 10
) (
   input  logic       CLK,
   input  logic       RST_N,
   input  logic       ID_READY,
   input  logic       EXIT_REQ,
   input  logic       id_valid,
   input  logic       id_special,
   input  logic       adminId_valid,
   input  logic       chosen_flr_full,
   input  logic       alternative_flr_full,
   input  logic       USER_ACCEPT,
   input  logic       USER_DECLINE,
   input  logic       CAR_PASSED,
   output logic [1:0] MODE,
   output logic [1:0] action_taken,
   output logic       GATE_OPEN,
   output logic       DENY,
   output logic       ALT_OFFER,
   output logic       BUSY,
   output logic       RESTRICTED
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_CHECK  = 3'd1,
      S_OFFER  = 3'd2,
      S_COMMIT = 3'd3,
      S_GATE   = 3'd4,
      S_DENY   = 3'd5
   } state_t;

   localparam logic [1:0] MODE_ENTER    = 2'd0;
   localparam logic [1:0] MODE_EXIT     = 2'd1;
   localparam logic [1:0] MODE_RESTRICT = 2'd2;

   localparam logic [1:0] ACT_NONE   = 2'd0;
   localparam logic [1:0] ACT_ALT    = 2'd1;
   localparam logic [1:0] ACT_CHOSEN = 2'd2;
   localparam logic [1:0] ACT_EXIT   = 2'd3;

   // Timer value on the last cycle of each timed state.
   localparam logic [CW-1:0] ALT_LAST  = CW'(ALT_TIMEOUT - 1);
   localparam logic [CW-1:0] GATE_LAST = CW'(GATE_TIMEOUT - 1);
   localparam logic [CW-1:0] DENY_LAST = CW'(DENY_CYCLES - 1);
   localparam logic [CW-1:0] TIMER_MAX = {CW{1'b1}};

   state_t        state_reg, state_next;
   logic [CW-1:0] timer_reg, timer_next;
   logic [1:0]    pend_reg, pend_next;        // action code to issue in COMMIT
   logic          restricted_reg, restricted_next;
   logic [1:0]    mode_reg, mode_next;
   logic [1:0]    action_reg, action_next;
   logic          gate_reg, gate_next;
   logic          deny_reg, deny_next;
   logic          alt_reg, alt_next;
   logic          busy_reg, busy_next;

   // ------------------------------------------------------------------------
   // State and output registers
   // ------------------------------------------------------------------------
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_reg      <= S_IDLE;
         timer_reg      <= '0;
         pend_reg       <= ACT_NONE;
         restricted_reg <= 1'b0;
         mode_reg       <= MODE_ENTER;
         action_reg     <= ACT_NONE;
         gate_reg       <= 1'b0;
         deny_reg       <= 1'b0;
         alt_reg        <= 1'b0;
         busy_reg       <= 1'b0;
      end else begin
         state_reg      <= state_next;
         timer_reg      <= timer_next;
         pend_reg       <= pend_next;
         restricted_reg <= restricted_next;
         mode_reg       <= mode_next;
         action_reg     <= action_next;
         gate_reg       <= gate_next;
         deny_reg       <= deny_next;
         alt_reg        <= alt_next;
         busy_reg       <= busy_next;
      end
   end

   // ------------------------------------------------------------------------
   // Next-state logic (also owns the timer, pending action and lock)
   // ------------------------------------------------------------------------
   always_comb begin
      state_next      = state_reg;
      pend_next       = pend_reg;
      restricted_next = restricted_reg;

      case (state_reg)
         S_IDLE: begin
            if (ID_READY) state_next = S_CHECK;
         end

         // Bookkeeping flags are valid this cycle because MODE was
         // registered on the ID_READY edge. Branch order is the priority.
         S_CHECK: begin
            if (adminId_valid) begin
               restricted_next = ~restricted_reg;
               state_next      = S_GATE;
            end else if (restricted_reg) begin
               state_next = S_DENY;
            end else if (mode_reg == MODE_EXIT) begin
               if (id_valid || id_special) begin
                  pend_next  = ACT_EXIT;
                  state_next = S_COMMIT;
               end else begin
                  state_next = S_DENY;
               end
            end else if (id_special || (id_valid && !chosen_flr_full)) begin
               pend_next  = ACT_CHOSEN;
               state_next = S_COMMIT;
            end else if (id_valid && !alternative_flr_full) begin
               state_next = S_OFFER;
            end else begin
               state_next = S_DENY;
            end
         end

         // Decline (or running out of time) beats a simultaneous accept.
         S_OFFER: begin
            if (USER_DECLINE || (timer_reg == ALT_LAST)) begin
               state_next = S_DENY;
            end else if (USER_ACCEPT) begin
               pend_next  = ACT_ALT;
               state_next = S_COMMIT;
            end
         end

         S_COMMIT: begin
            state_next = S_GATE;
         end

         // A timeout closes the gate without undoing the commit.
         S_GATE: begin
            if (CAR_PASSED || (timer_reg == GATE_LAST)) state_next = S_IDLE;
         end

         S_DENY: begin
            if (timer_reg == DENY_LAST) state_next = S_IDLE;
         end

         default: begin
            state_next = S_IDLE;
         end
      endcase

      // Timer restarts on every state change and saturates otherwise.
      if (state_next != state_reg) begin
         timer_next = '0;
      end else if (timer_reg == TIMER_MAX) begin
         timer_next = timer_reg;
      end else begin
         timer_next = timer_reg + 1'b1;
      end
   end

   // ------------------------------------------------------------------------
   // Output logic: next values of the registered outputs, derived from the
   // state being entered so each output lines up with its state.
   // ------------------------------------------------------------------------
   always_comb begin
      mode_next = mode_reg;
      if ((state_reg == S_IDLE) && (state_next == S_CHECK)) begin
         mode_next = {1'b0, EXIT_REQ};
      end else if (state_next == S_IDLE) begin
         mode_next = restricted_next ? MODE_RESTRICT : MODE_ENTER;
      end

      action_next = (state_next == S_COMMIT) ? pend_next : ACT_NONE;
      gate_next   = (state_next == S_GATE);
      deny_next   = (state_next == S_DENY);
      alt_next    = (state_next == S_OFFER);
      busy_next   = (state_next != S_IDLE);
   end

   assign MODE         = mode_reg;
   assign action_taken = action_reg;
   assign GATE_OPEN    = gate_reg;
   assign DENY         = deny_reg;
   assign ALT_OFFER    = alt_reg;
   assign BUSY         = busy_reg;
   assign RESTRICTED   = restricted_reg;

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Testbench for parking_gate_ctrl. Each transaction's outcome is decided from
// the flag priority rules, then expanded into an expected output waveform
// (phase lengths computed arithmetically). A single compare process checks
// every cycle against that waveform.
module tb_parking_gate_ctrl;

   localparam int ALT_T  = 200;
   localparam int GATE_T = 500;
   localparam int DENY_C = 50;

   logic       CLK = 1'b0;
   logic       RST_N = 1'b0;
   logic       ID_READY = 1'b0;
   logic       EXIT_REQ = 1'b0;
   logic       id_valid = 1'b0;
   logic       id_special = 1'b0;
   logic       adminId_valid = 1'b0;
   logic       chosen_flr_full = 1'b0;
   logic       alternative_flr_full = 1'b0;
   logic       USER_ACCEPT = 1'b0;
   logic       USER_DECLINE = 1'b0;
   logic       CAR_PASSED = 1'b0;
   logic [1:0] MODE;
   logic [1:0] action_taken;
   logic       GATE_OPEN;
   logic       DENY;
   logic       ALT_OFFER;
   logic       BUSY;
   logic       RESTRICTED;

   parking_gate_ctrl #(
      .ALT_TIMEOUT (ALT_T),
      .GATE_TIMEOUT(GATE_T),
      .DENY_CYCLES (DENY_C),
      .CW          (10)
   ) dut (
      .CLK                 (CLK),
      .RST_N               (RST_N),
      .ID_READY            (ID_READY),
      .EXIT_REQ            (EXIT_REQ),
      .id_valid            (id_valid),
      .id_special          (id_special),
      .adminId_valid       (adminId_valid),
      .chosen_flr_full     (chosen_flr_full),
      .alternative_flr_full(alternative_flr_full),
      .USER_ACCEPT         (USER_ACCEPT),
      .USER_DECLINE        (USER_DECLINE),
      .CAR_PASSED          (CAR_PASSED),
      .MODE                (MODE),
      .action_taken        (action_taken),
      .GATE_OPEN           (GATE_OPEN),
      .DENY                (DENY),
      .ALT_OFFER           (ALT_OFFER),
      .BUSY                (BUSY),
      .RESTRICTED          (RESTRICTED)
   );

   always #5 CLK = ~CLK;

   typedef struct packed {
      logic [1:0] mode;
      logic [1:0] act;
      logic       gate;
      logic       deny;
      logic       alt;
      logic       busy;
      logic       restr;
   } outs_t;

   outs_t dut_o;
   outs_t exp_o;
   bit    exp_en;
   logic  m_restr;
   int    checks, errors;
   int    cnt_alt, cnt_deny, cnt_gate, cnt_act_nz, last_act;

   assign dut_o = {MODE, action_taken, GATE_OPEN, DENY, ALT_OFFER, BUSY, RESTRICTED};

   function automatic outs_t mk(logic [1:0] mode, logic [1:0] act, logic g, logic d,
                                logic a, logic b, logic r);
      outs_t o;
      o.mode = mode; o.act = act; o.gate = g; o.deny = d;
      o.alt = a; o.busy = b; o.restr = r;
      return o;
   endfunction

   function automatic outs_t idle_exp();
      return mk(m_restr ? 2'd2 : 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, m_restr);
   endfunction

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic check(input string name, input int got, input int want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s got=%0d expected=%0d", name, got, want);
      end
   endtask

   task automatic clr();
      cnt_alt = 0; cnt_deny = 0; cnt_gate = 0; cnt_act_nz = 0; last_act = 0;
   endtask

   task automatic gap(input int n);
      repeat (n) begin
         tick();
         exp_o = idle_exp();
      end
   endtask

   // ID_READY pulses while busy must be ignored by the DUT.
   task automatic drive_noise(input bit noise);
      if (noise) begin
         ID_READY = ($urandom_range(0, 5) == 0);
         EXIT_REQ = 1'($urandom_range(0, 1));
      end
   endtask

   // rkind: 0 none, 1 accept, 2 decline, 3 both; rk = offer cycle of response
   // ck = gate cycle of CAR_PASSED (>= GATE_T means no car)
   task automatic run_txn(input bit ex, input bit v, input bit sp, input bit adm,
                          input bit cf, input bit af, input int rkind, input int rk,
                          input int ck, input bit noise);
      logic [1:0] m;
      logic [1:0] code;
      logic       r_new;
      int         outcome;   // 0 deny, 1 commit, 2 offer, 3 admin gate
      int         n_off, g;
      m = {1'b0, ex};
      r_new = m_restr;
      code = 2'd0;
      if (adm) begin outcome = 3; r_new = ~m_restr; end
      else if (m_restr) outcome = 0;
      else if (ex) begin
         if (v || sp) begin outcome = 1; code = 2'd3; end
         else outcome = 0;
      end
      else if (sp) begin outcome = 1; code = 2'd2; end
      else if (v && !cf) begin outcome = 1; code = 2'd2; end
      else if (v && !af) outcome = 2;
      else outcome = 0;

      EXIT_REQ = ex; id_valid = v; id_special = sp; adminId_valid = adm;
      chosen_flr_full = cf; alternative_flr_full = af;
      ID_READY = 1'b1;
      tick();
      ID_READY = 1'b0;
      exp_o = mk(m, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, m_restr);
      m_restr = r_new;
      tick();

      if (outcome == 2) begin
         n_off = (rkind != 0 && rk < ALT_T - 1) ? rk + 1 : ALT_T;
         for (int i = 0; i < n_off; i++) begin
            exp_o = mk(m, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, m_restr);
            USER_ACCEPT  = (i == rk) && (rkind == 1 || rkind == 3);
            USER_DECLINE = (i == rk) && (rkind == 2 || rkind == 3);
            drive_noise(noise);
            tick();
         end
         USER_ACCEPT = 1'b0; USER_DECLINE = 1'b0;
         if (rkind == 1 && rk < ALT_T - 1) begin outcome = 1; code = 2'd1; end
         else outcome = 0;
      end

      if (outcome == 1) begin
         exp_o = mk(m, code, 1'b0, 1'b0, 1'b0, 1'b1, m_restr);
         drive_noise(noise);
         tick();
      end

      if (outcome == 1 || outcome == 3) begin
         g = (ck < GATE_T - 1) ? ck + 1 : GATE_T;
         for (int i = 0; i < g; i++) begin
            exp_o = mk(m, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1, m_restr);
            CAR_PASSED = (i == ck);
            drive_noise(noise);
            tick();
         end
         CAR_PASSED = 1'b0;
      end else begin
         for (int i = 0; i < DENY_C; i++) begin
            exp_o = mk(m, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1, m_restr);
            drive_noise(noise);
            tick();
         end
      end
      ID_READY = 1'b0;
      exp_o = idle_exp();
   endtask

   initial begin
      exp_en = 1'b0; m_restr = 1'b0; checks = 0; errors = 0;
      clr();
      exp_o = idle_exp();

      fork
         forever begin
            @(negedge CLK);
            if (ALT_OFFER) cnt_alt++;
            if (DENY) cnt_deny++;
            if (GATE_OPEN) cnt_gate++;
            if (action_taken != 2'd0) begin
               cnt_act_nz++;
               last_act = int'(action_taken);
            end
            if (exp_en) begin
               checks++;
               if (dut_o !== exp_o) begin
                  errors++;
                  $display("FAIL cycle_cmp t=%0t got mode=%0d act=%0d gate=%b deny=%b alt=%b busy=%b restr=%b expected mode=%0d act=%0d gate=%b deny=%b alt=%b busy=%b restr=%b",
                           $time, dut_o.mode, dut_o.act, dut_o.gate, dut_o.deny, dut_o.alt,
                           dut_o.busy, dut_o.restr, exp_o.mode, exp_o.act, exp_o.gate,
                           exp_o.deny, exp_o.alt, exp_o.busy, exp_o.restr);
               end
            end
         end
         begin
            #3000000;
            $display("FAIL watchdog got=running expected=finished");
            $fatal(1, "watchdog expired");
         end
      join_none

      // Reset state
      tick(); tick();
      check("reset_outs", int'(dut_o), 0);
      #2 RST_N = 1'b1;
      exp_o = idle_exp();
      exp_en = 1'b1;
      gap(3);

      // Entry, chosen floor free, car passes on 4th gate cycle
      clr(); run_txn(0, 1, 0, 0, 0, 0, 0, 0, 3, 0); gap(2);
      check("entry_act_count", cnt_act_nz, 1);
      check("entry_act_code", last_act, 2);
      check("entry_gate_cycles", cnt_gate, 4);

      // Alternative offer accepted on the 10th offer cycle
      clr(); run_txn(0, 1, 0, 0, 1, 0, 1, 9, 2, 0); gap(2);
      check("alt_offer_cycles", cnt_alt, 10);
      check("alt_act_count", cnt_act_nz, 1);
      check("alt_act_code", last_act, 1);

      // Alternative offer with no response
      clr(); run_txn(0, 1, 0, 0, 1, 0, 0, 0, 2, 0); gap(2);
      check("alt_timeout_cycles", cnt_alt, 200);
      check("alt_timeout_deny", cnt_deny, 50);
      check("alt_timeout_act", cnt_act_nz, 0);

      // Both floors full, then invalid ID
      clr(); run_txn(0, 1, 0, 0, 1, 1, 0, 0, 2, 0); run_txn(0, 0, 0, 0, 0, 0, 0, 0, 2, 0); gap(2);
      check("deny_cycles", cnt_deny, 100);
      check("deny_gate", cnt_gate, 0);
      check("deny_act", cnt_act_nz, 0);

      // Exit, no car: gate times out
      clr(); run_txn(1, 1, 0, 0, 0, 0, 0, 0, 600, 0); gap(2);
      check("exit_act_code", last_act, 3);
      check("exit_gate_timeout", cnt_gate, 500);

      // Admin sets the lock, normal entry denied, admin clears the lock
      clr(); run_txn(0, 0, 0, 1, 0, 0, 0, 0, 0, 0); gap(2);
      check("admin_restricted", int'(RESTRICTED), 1);
      check("admin_mode_idle", int'(MODE), 2);
      check("admin_gate", cnt_gate, 1);
      clr(); run_txn(0, 1, 0, 0, 0, 0, 0, 0, 3, 0); gap(2);
      check("locked_deny", cnt_deny, 50);
      check("locked_act", cnt_act_nz, 0);
      run_txn(0, 0, 0, 1, 0, 0, 0, 0, 1, 0); gap(2);
      check("admin2_restricted", int'(RESTRICTED), 0);
      check("admin2_mode_idle", int'(MODE), 0);

      // Reset during OFFER (with an ignored ID_READY pulse beforehand)
      EXIT_REQ = 1'b0; id_valid = 1'b1; id_special = 1'b0; adminId_valid = 1'b0;
      chosen_flr_full = 1'b1; alternative_flr_full = 1'b0;
      ID_READY = 1'b1; tick(); ID_READY = 1'b0;
      exp_o = mk(2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, m_restr);
      tick();
      exp_o = mk(2'd0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, m_restr);
      ID_READY = 1'b1; tick(); ID_READY = 1'b0;
      exp_o = mk(2'd0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, m_restr);
      tick();
      exp_en = 1'b0;
      check("offer_alt_pre", int'(ALT_OFFER), 1);
      #2 RST_N = 1'b0;
      #1 check("rst_offer_outs", int'(dut_o), 0);
      m_restr = 1'b0;
      tick(); ID_READY = 1'b1; tick(); ID_READY = 1'b0;
      #2 RST_N = 1'b1;
      exp_o = idle_exp(); exp_en = 1'b1;
      gap(3);

      // Reset during COMMIT
      chosen_flr_full = 1'b0;
      ID_READY = 1'b1; tick(); ID_READY = 1'b0;
      exp_o = mk(2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, m_restr);
      tick();
      exp_en = 1'b0;
      check("commit_act_pre", int'(action_taken), 2);
      #2 RST_N = 1'b0;
      #1 check("rst_commit_outs", int'(dut_o), 0);
      tick();
      #2 RST_N = 1'b1;
      exp_o = idle_exp(); exp_en = 1'b1;
      clr(); gap(5);
      check("no_act_after_rst", cnt_act_nz, 0);

      // Randomized transactions
      for (int t = 0; t < 80; t++) begin
         bit ex, v, sp, adm, cf, af;
         int rkind, rk, ck;
         ex  = 1'($urandom_range(0, 1));
         v   = ($urandom_range(0, 3) != 0);
         sp  = ($urandom_range(0, 5) == 0);
         adm = ($urandom_range(0, 9) == 0);
         cf  = 1'($urandom_range(0, 1));
         af  = 1'($urandom_range(0, 1));
         rkind = int'($urandom_range(0, 3));
         rk = ($urandom_range(0, 9) == 0) ? int'($urandom_range(195, 205)) : int'($urandom_range(0, 20));
         ck = ($urandom_range(0, 9) == 0) ? 600 : int'($urandom_range(0, 15));
         run_txn(ex, v, sp, adm, cf, af, rkind, rk, ck, 1'b1);
         gap(int'($urandom_range(0, 3)));
      end

      exp_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
